// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive front-end.
// Holds the frame FSM state encoding, the legal oversample ratios and the parity-type codes.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } rx_state_e;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    // Parity bit the transmitter should have sent, given the XOR of the payload.
    function automatic logic parity_bit(input logic data_xor, input logic par_typ);
        return data_xor ^ par_typ;
    endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Serial-line, configuration and frame-output bundle of the UART receiver.
// The slave side is the receiver; the master side drives the line and consumes frames.
interface uart_rx_frame_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);

    logic                      RX_IN;
    logic [PRESCALE_WIDTH-1:0] PRESCALE;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      DATA_VALID;
    logic                      PAR_ERR;
    logic                      STP_ERR;

    modport master (
        output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );

    modport slave (
        input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );

endinterface

// File: rtl/uart_rx_sampler.sv
// RX line synchroniser, per-bit edge counter and three-sample mid-bit majority vote.
// The counter free-runs 0..prescale-1 while run is high and parks at 0 otherwise.
module uart_rx_sampler #(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      rx_in,
    input  logic                      run,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      line,
    output logic [PRESCALE_WIDTH-1:0] ec,
    output logic                      sampled_bit,
    output logic                      bit_done
);

    logic                      sync1;
    logic                      sync2;
    logic [2:0]                samples;
    logic [PRESCALE_WIDTH-1:0] half;

    assign half = {1'b0, prescale[PRESCALE_WIDTH-1:1]};

    // NOTE: synchroniser flops reset to the idle-high line level so that
    // reset release never looks like a falling start edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx_in;
            sync2 <= sync1;
        end
    end

    assign line     = sync2;
    assign bit_done = (ec == prescale - PRESCALE_WIDTH'(1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ec <= '0;
        end else if (run) begin
            ec <= bit_done ? '0 : ec + PRESCALE_WIDTH'(1);
        end else begin
            ec <= '0;
        end
    end

    // Three consecutive samples centred on mid-bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samples <= 3'b111;
        end else begin
            if (ec == half - PRESCALE_WIDTH'(2)) samples[0] <= line;
            if (ec == half - PRESCALE_WIDTH'(1)) samples[1] <= line;
            if (ec == half)                      samples[2] <= line;
        end
    end

    assign sampled_bit = (samples[0] & samples[1]) |
                         (samples[0] & samples[2]) |
                         (samples[1] & samples[2]);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive frame engine: start/data/parity/stop FSM around the oversampling sampler.
// Emits registered one-cycle DATA_VALID / PAR_ERR / STP_ERR pulses during the DONE cycle.
module uart_rx_frame
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic            CLK,
    input  logic            RST,
    uart_rx_frame_if.slave  rx
);

    localparam int BC_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BC_WIDTH-1:0] LAST_BIT = BC_WIDTH'(DATA_WIDTH - 1);

    rx_state_e                 state_q;
    rx_state_e                 state_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic                      par_en_q;
    logic                      par_typ_q;
    logic [DATA_WIDTH-1:0]     shift_q;
    logic [BC_WIDTH-1:0]       bc_q;
    logic                      par_flag_q;

    logic                      line;
    logic [PRESCALE_WIDTH-1:0] ec;
    logic                      sampled_bit;
    logic                      bit_done;
    logic                      vote_ready;
    logic                      run;
    logic                      start_det;
    logic                      valid_d;
    logic                      par_err_d;
    logic                      stp_err_d;

    uart_rx_sampler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .rx_in       (rx.RX_IN),
        .run         (run),
        .prescale    (prescale_q),
        .line        (line),
        .ec          (ec),
        .sampled_bit (sampled_bit),
        .bit_done    (bit_done)
    );

    // Majority vote is settled one edge after the last mid-bit sample.
    assign vote_ready = (ec == {1'b0, prescale_q[PRESCALE_WIDTH-1:1]} + PRESCALE_WIDTH'(1));
    assign start_det  = ((state_q == IDLE) || (state_q == DONE)) && !line;

    // NOTE: every signal driven here gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d   = state_q;
        valid_d   = 1'b0;
        par_err_d = 1'b0;
        stp_err_d = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = line ? IDLE : START;
            end
            START: begin
                if (vote_ready && sampled_bit) begin
                    state_d = IDLE;
                end else if (bit_done) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done && (bc_q == LAST_BIT)) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_done) state_d = STOP;
            end
            STOP: begin
                if (bit_done) begin
                    state_d = DONE;
                    if (par_flag_q)        par_err_d = 1'b1;
                    else if (!sampled_bit) stp_err_d = 1'b1;
                    else                   valid_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The edge counter runs for exactly the cycles that belong to a frame bit;
    // leaving START on a glitch or finishing STOP parks it back at zero.
    assign run = (state_d == START) || (state_d == DATA) ||
                 (state_d == PARITY) || (state_d == STOP);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= IDLE;
            prescale_q    <= PRESCALE_WIDTH'(PRESCALE_8);
            par_en_q      <= 1'b0;
            par_typ_q     <= EVEN;
            shift_q       <= '0;
            bc_q          <= '0;
            par_flag_q    <= 1'b0;
            rx.P_DATA     <= '0;
            rx.DATA_VALID <= 1'b0;
            rx.PAR_ERR    <= 1'b0;
            rx.STP_ERR    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx.DATA_VALID <= valid_d;
            rx.PAR_ERR    <= par_err_d;
            rx.STP_ERR    <= stp_err_d;
            if (valid_d) rx.P_DATA <= shift_q;

            // Configuration is frozen for the whole frame at its start edge.
            if (start_det) begin
                prescale_q <= rx.PRESCALE;
                par_en_q   <= rx.PAR_EN;
                par_typ_q  <= rx.PAR_TYP;
                par_flag_q <= 1'b0;
                bc_q       <= '0;
            end

            if ((state_q == DATA) && bit_done) begin
                shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                bc_q    <= (bc_q == LAST_BIT) ? '0 : bc_q + BC_WIDTH'(1);
            end

            if ((state_q == PARITY) && bit_done) begin
                par_flag_q <= (sampled_bit != parity_bit(^shift_q, par_typ_q));
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed testbench for uart_rx_frame: hand-computed frames, latencies and error pulses.
// Latencies are measured from the negedge the start bit is driven to the negedge the pulse is seen.
module tb_uart_rx_frame;
    import uart_rx_pkg::*;

    localparam int DW = 8;
    localparam int PW = 6;

    localparam logic [2:0] K_VALID = 3'b100;
    localparam logic [2:0] K_PAR   = 3'b010;
    localparam logic [2:0] K_STP   = 3'b001;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    uart_rx_frame_if #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) rx_if ();

    uart_rx_frame #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .CLK (CLK),
        .RST (RST),
        .rx  (rx_if.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int unsigned cyc;
        logic [2:0]  kind;
        logic [7:0]  data;
    } ev_t;

    ev_t         evq[$];
    ev_t         mon_ev;
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Log every output pulse with the cycle it was seen in.
    always @(negedge CLK) begin
        if (RST && (rx_if.DATA_VALID || rx_if.PAR_ERR || rx_if.STP_ERR)) begin
            mon_ev.cyc  = cyc;
            mon_ev.kind = {rx_if.DATA_VALID, rx_if.PAR_ERR, rx_if.STP_ERR};
            mon_ev.data = rx_if.P_DATA;
            evq.push_back(mon_ev);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Hold one bit for p cycles; optionally invert it for the single cycle at offset g.
    task automatic drive_bit(input logic v, input int p, input int g);
        for (int i = 0; i < p; i++) begin
            rx_if.RX_IN = (i == g) ? ~v : v;
            @(negedge CLK);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input logic par_en,
                              input logic par_bit, input logic stop_bit,
                              input int glitch_bit, output int unsigned t_start);
        t_start = cyc;
        drive_bit(1'b0, p, -1);
        for (int i = 0; i < DW; i++) begin
            drive_bit(d[i], p, (i == glitch_bit) ? (p / 2 - 1) : -1);
        end
        if (par_en) drive_bit(par_bit, p, -1);
        drive_bit(stop_bit, p, -1);
        rx_if.RX_IN = 1'b1;
    endtask

    task automatic expect_single(input string tag, input logic [2:0] kind,
                                 input int unsigned t_start, input int unsigned lat,
                                 input logic [7:0] data);
        check({tag, " pulses"}, evq.size(), 1);
        if (evq.size() > 0) begin
            check({tag, " kind"}, evq[0].kind, kind);
            check({tag, " latency"}, evq[0].cyc - t_start, lat);
            check({tag, " data"}, evq[0].data, data);
        end
        evq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t;
        int unsigned tb2b[4];
        logic [7:0]  b2b_data[4];

        b2b_data = '{8'hAA, 8'h05, 8'hBB, 8'h05};
        rx_if.RX_IN    = 1'b1;
        rx_if.PRESCALE = PW'(PRESCALE_8);
        rx_if.PAR_EN   = 1'b0;
        rx_if.PAR_TYP  = EVEN;
        RST            = 1'b0;
        settle(3);
        check("reset P_DATA", rx_if.P_DATA, 0);
        check("reset DATA_VALID", rx_if.DATA_VALID, 0);
        check("reset PAR_ERR", rx_if.PAR_ERR, 0);
        check("reset STP_ERR", rx_if.STP_ERR, 0);
        RST = 1'b1;
        settle(4);

        // P=8, no parity: pulse 10*8 cycles after t0, t0 is 2 cycles after the pin.
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1, t);
        settle(6);
        expect_single("p8 a5", K_VALID, t, 82, 8'hA5);
        check("p8 a5 held", rx_if.P_DATA, 8'hA5);

        // P=16, even parity: 0xDD has six ones, parity bit 0 is correct.
        rx_if.PRESCALE = PW'(PRESCALE_16);
        rx_if.PAR_EN   = 1'b1;
        rx_if.PAR_TYP  = EVEN;
        send_frame(8'hDD, 16, 1'b1, 1'b0, 1'b1, -1, t);
        settle(6);
        expect_single("p16 even dd", K_VALID, t, 178, 8'hDD);
        send_frame(8'hDD, 16, 1'b1, 1'b1, 1'b1, -1, t);
        settle(6);
        expect_single("p16 par err", K_PAR, t, 178, 8'hDD);

        // Odd parity: 0x01 has one 1, so the odd parity bit is 0.
        rx_if.PAR_TYP = ODD;
        send_frame(8'h01, 16, 1'b1, 1'b0, 1'b1, -1, t);
        settle(6);
        expect_single("p16 odd 01", K_VALID, t, 178, 8'h01);

        // P=32, no parity, stop bit low: STP_ERR, P_DATA keeps 0x01.
        rx_if.PRESCALE = PW'(PRESCALE_32);
        rx_if.PAR_EN   = 1'b0;
        send_frame(8'h3C, 32, 1'b0, 1'b0, 1'b0, -1, t);
        settle(6);
        expect_single("p32 stop err", K_STP, t, 322, 8'h01);
        send_frame(8'h11, 32, 1'b0, 1'b0, 1'b1, -1, t);
        settle(6);
        expect_single("p32 11", K_VALID, t, 322, 8'h11);

        // Three-cycle start glitch at P=16 is rejected without any pulse.
        rx_if.PRESCALE = PW'(PRESCALE_16);
        rx_if.RX_IN    = 1'b0;
        settle(3);
        rx_if.RX_IN = 1'b1;
        settle(40);
        check("glitch pulses", evq.size(), 0);
        evq.delete();

        // Four back-to-back frames, one pulse every 160 cycles.
        for (int i = 0; i < 4; i++) begin
            send_frame(b2b_data[i], 16, 1'b0, 1'b0, 1'b1, -1, tb2b[i]);
        end
        settle(6);
        check("b2b pulses", evq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < evq.size()) begin
                check($sformatf("b2b%0d kind", i), evq[i].kind, K_VALID);
                check($sformatf("b2b%0d data", i), evq[i].data, b2b_data[i]);
                check($sformatf("b2b%0d latency", i), evq[i].cyc - tb2b[i], 162);
                if (i > 0) check($sformatf("b2b%0d spacing", i), evq[i].cyc - evq[i-1].cyc, 160);
            end
        end
        evq.delete();

        // P=8, one corrupted mid-bit sample on data bit 2 is outvoted.
        rx_if.PRESCALE = PW'(PRESCALE_8);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 2, t);
        settle(6);
        expect_single("noise 5a", K_VALID, t, 82, 8'h5A);

        // PRESCALE changed mid-frame does not disturb the frame in flight.
        fork
            send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, -1, t);
            begin
                settle(20);
                rx_if.PRESCALE = PW'(PRESCALE_16);
            end
        join
        rx_if.PRESCALE = PW'(PRESCALE_8);
        settle(6);
        expect_single("prescale change c3", K_VALID, t, 82, 8'hC3);

        // Reset during the data bits of 0x7E: outputs clear at once, no pulse.
        drive_bit(1'b0, 8, -1);
        drive_bit(1'b0, 8, -1);
        drive_bit(1'b1, 8, -1);
        drive_bit(1'b1, 8, -1);
        RST = 1'b0;
        #1;
        check("mid reset P_DATA", rx_if.P_DATA, 0);
        check("mid reset DATA_VALID", rx_if.DATA_VALID, 0);
        check("mid reset PAR_ERR", rx_if.PAR_ERR, 0);
        check("mid reset STP_ERR", rx_if.STP_ERR, 0);
        rx_if.RX_IN = 1'b1;
        @(negedge CLK);
        settle(2);
        RST = 1'b1;
        settle(100);
        check("mid reset pulses", evq.size(), 0);
        evq.delete();
        send_frame(8'h42, 8, 1'b0, 1'b0, 1'b1, -1, t);
        settle(6);
        expect_single("after reset 42", K_VALID, t, 82, 8'h42);
        check("after reset held", rx_if.P_DATA, 8'h42);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
UART receiver front-end that turns the serial RX pin into byte-wide frames for the system controller's command stream (P_DATA/DATA_VALID feed the RX data synchroniser ahead of RX_P_DATA/RX_D_VLD). It oversamples the line by a runtime prescale and majority-votes each bit at mid-bit. It checks optional parity and the stop bit, and emits one-cycle valid/error pulses per frame. Runs entirely in the UART clock domain, CLK = baud x PRESCALE.

Parameters:
DATA_WIDTH, 8, payload bits per frame (LSB first)
PRESCALE_WIDTH, 6, width of PRESCALE port

Ports:
CLK  in  1  oversampling clock
RST  in  1  reset, asynchronous, active-low
RX_IN  in  1  serial line, idle high, asynchronous to CLK
PRESCALE  in  PRESCALE_WIDTH  oversample ratio; legal 8, 16, 32
PAR_EN  in  1  1 = parity bit present
PAR_TYP  in  1  0 = even, 1 = odd
P_DATA  out  DATA_WIDTH  last good frame payload, held until next good frame
DATA_VALID  out  1  one-cycle pulse: P_DATA updated
PAR_ERR  out  1  one-cycle pulse: parity mismatch, frame dropped
STP_ERR  out  1  one-cycle pulse: stop bit sampled 0, frame dropped

Behaviour:
- Reset: FSM=IDLE, counters 0, P_DATA=0, DATA_VALID=PAR_ERR=STP_ERR=0, synchroniser flops=1. Reset mid-frame discards the partial frame silently; no error pulse.
- RX_IN passes a 2-flop synchroniser; "line" below means synchroniser output. Pin-to-line latency is 2 CLK.
- Config capture: PRESCALE, PAR_EN, PAR_TYP latched at start detection. Changes mid-frame have no effect until the next frame.
- Edge counter ec counts 0..P-1 per bit period, where P is the captured PRESCALE. Bit counter bc indexes the bits of the frame.
- Sampling: line sampled at ec = P/2-2, P/2-1, P/2. Bit value = majority of the 3 samples, valid from ec = P/2+1.
- States:
  IDLE: line=0 -> START, ec=0. This cycle is t0.
  START: majority=1 -> IDLE (glitch reject, no pulse). Majority=0 -> DATA at ec=P-1.
  DATA: shift bit into DATA_WIDTH shift register, LSB first. After bit DATA_WIDTH-1 at ec=P-1 -> PARITY if PAR_EN, else STOP.
  PARITY: expected = XOR(data) XOR PAR_TYP. Mismatch sets an internal flag. -> STOP at ec=P-1.
  STOP: at ec=P-1 -> DONE.
  DONE: one cycle.
    - Parity flag set: PAR_ERR=1.
    - Else stop bit=0: STP_ERR=1.
    - Else: P_DATA<=shift reg, DATA_VALID=1.
    - Then -> IDLE, or straight to START (ec=0, this cycle is the new t0) if line=0. This supports back-to-back frames.
- Latency: pulse in cycle t0 + N*P, with N = 1 + DATA_WIDTH + PAR_EN + 1.
- Priority: PAR_ERR over STP_ERR; never more than one pulse per frame. DATA_VALID is never asserted with an error.
- Pulses are exactly one CLK wide; the consumer must sample every cycle, there is no backpressure.
- Illegal PRESCALE (<6 or odd): behaviour undefined, no hang guarantee beyond the next reset.
- Line stuck low after a frame: each P*N period yields STP_ERR (break condition). No lockup.

Decomposition:
- Package uart_rx_pkg: state enum (IDLE, START, DATA, PARITY, STOP, DONE); localparams PRESCALE_8=8, PRESCALE_16=16, PRESCALE_32=32; parity-type constants EVEN=0, ODD=1.
- Sub-module uart_rx_sampler: synchroniser, edge counter, 3-sample majority vote. Outputs ec, sampled_bit, bit_done. The FSM, shift register, parity and stop checks stay in the top.

Test Plan:
- PRESCALE=8, PAR_EN=0, frame 0xA5 -> DATA_VALID single pulse at t0+80, P_DATA=0xA5, no errors.
- PRESCALE=16, PAR_EN=1, PAR_TYP=0, 0xDD with parity 0 -> DATA_VALID at t0+176, P_DATA=0xDD. Same frame with parity 1 -> PAR_ERR pulse, P_DATA stays 0xDD from before.
- PRESCALE=32, stop bit driven 0 on 0x3C -> STP_ERR at t0+320, DATA_VALID stays 0, next good frame 0x11 -> P_DATA=0x11.
- Start glitch: RX_IN low 3 CLK at PRESCALE=16 -> FSM returns to IDLE, no pulses. Then frames AA,05,BB,05 sent back-to-back -> four DATA_VALID pulses exactly 10*P apart.
- Single-sample noise on one data bit mid-bit at P=8 -> majority vote masks it, byte correct. PRESCALE changed mid-frame -> current frame unaffected.
- Assert RST during DATA of frame 0x7E -> all outputs 0 immediately, no pulse. After release, frame 0x42 -> P_DATA=0x42.
